// File: rtl/sprite_fetch.sv
// Sprite pattern fetch: walks secondary OAM, fetches both pattern planes per slot
// and loads eight packed records into the sprite shifters. Optional macro: SPRITE_FETCH_DUMMY_EN.
module sprite_fetch #(
    parameter int PAT_AW = 13
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              ce,
    input  logic              i_fetch_start,
    input  logic              i_obj_size,
    input  logic              i_pat_base,
    output logic [4:0]        o_temp_addr,
    input  logic [7:0]        i_temp_data,
    output logic              o_pat_req,
    output logic [PAT_AW-1:0] o_pat_addr,
    input  logic              i_pat_ack,
    input  logic [7:0]        i_pat_data,
    output logic [3:0]        o_load,
    output logic [26:0]       o_load_data,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [3:0] {
        S_IDLE, S_A0, S_A1, S_A2, S_A3, S_A4, S_P0, S_P1, S_LD, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  slot_q, slot_d;
    logic [7:0]  yoff_q, yoff_d;
    logic [7:0]  tile_q, tile_d;
    logic [7:0]  attr_q, attr_d;
    logic [7:0]  x_q, x_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;

    logic        slot_empty;
    logic        plane;
    logic [7:0]  fetch_tile;
    logic [3:0]  fetch_row;
    logic [12:0] pat_addr;
    logic [7:0]  lo_out;
    logic [7:0]  hi_out;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // The shifter emits bit 0 first, so unflipped sprites are bit-reversed here.
    always_comb begin
        slot_empty = (yoff_q[7:4] != 4'h0);
        fetch_tile = tile_q;
        fetch_row  = yoff_q[3:0] ^ (attr_q[7] ? (i_obj_size ? 4'hF : 4'h7) : 4'h0);
`ifdef SPRITE_FETCH_DUMMY_EN
        if (slot_empty) begin
            fetch_tile = 8'hFF;
            fetch_row  = 4'h0;
        end
`endif
        plane = (state_q == S_P1);
        if (i_obj_size) begin
            pat_addr = {fetch_tile[0], fetch_tile[7:1], fetch_row[3], plane, fetch_row[2:0]};
        end else begin
            pat_addr = {i_pat_base, fetch_tile, plane, fetch_row[2:0]};
        end
        lo_out = attr_q[6] ? lo_q : rev8(lo_q);
        hi_out = attr_q[6] ? hi_q : rev8(hi_q);
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        yoff_d      = yoff_q;
        tile_d      = tile_q;
        attr_d      = attr_q;
        x_d         = x_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        o_temp_addr = 5'd0;
        o_pat_req   = 1'b0;
        o_pat_addr  = '0;
        o_load      = 4'h0;
        o_load_data = 27'd0;
        o_busy      = 1'b1;
        o_done      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                o_busy = 1'b0;
                if (ce && i_fetch_start) begin
                    state_d = S_A0;
                    slot_d  = 3'd0;
                end
            end
            S_A0: begin
                o_temp_addr = {slot_q, 2'b00};
                if (ce) state_d = S_A1;
            end
            S_A1: begin
                o_temp_addr = {slot_q, 2'b01};
                if (ce) begin
                    yoff_d  = i_temp_data;
                    state_d = S_A2;
                end
            end
            S_A2: begin
                o_temp_addr = {slot_q, 2'b10};
                if (ce) begin
                    tile_d  = i_temp_data;
                    state_d = S_A3;
                end
            end
            S_A3: begin
                o_temp_addr = {slot_q, 2'b11};
                if (ce) begin
                    attr_d  = i_temp_data;
                    state_d = S_A4;
                end
            end
            S_A4: begin
                if (ce) begin
                    x_d = i_temp_data;
`ifdef SPRITE_FETCH_DUMMY_EN
                    state_d = S_P0;
`else
                    state_d = slot_empty ? S_LD : S_P0;
`endif
                end
            end
            S_P0: begin
                o_pat_req  = 1'b1;
                o_pat_addr = PAT_AW'(pat_addr);
                if (ce && i_pat_ack) begin
                    lo_d    = i_pat_data;
                    state_d = S_P1;
                end
            end
            S_P1: begin
                o_pat_req  = 1'b1;
                o_pat_addr = PAT_AW'(pat_addr);
                if (ce && i_pat_ack) begin
                    hi_d    = i_pat_data;
                    state_d = S_LD;
                end
            end
            S_LD: begin
                o_load      = ce ? 4'hF : 4'h0;
                o_load_data = slot_empty ? {16'h0000, 8'hFF, 3'b000}
                                         : {lo_out, hi_out, x_q, attr_q[1:0], attr_q[5]};
                if (ce) begin
                    slot_d  = slot_q + 3'd1;
                    state_d = (slot_q == 3'd7) ? S_DONE : S_A0;
                end
            end
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                if (ce) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            slot_q  <= 3'd0;
            yoff_q  <= 8'd0;
            tile_q  <= 8'd0;
            attr_q  <= 8'd0;
            x_q     <= 8'd0;
            lo_q    <= 8'd0;
            hi_q    <= 8'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            yoff_q  <= yoff_d;
            tile_q  <= tile_d;
            attr_q  <= attr_d;
            x_q     <= x_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
        end
    end

endmodule

// File: tb/tb_sprite_fetch.sv
// Directed testbench for sprite_fetch: secondary OAM and pattern memory models,
// load/request monitors, and one task per scenario with hand-computed expectations.
module tb_sprite_fetch;

`ifdef SPRITE_FETCH_DUMMY_EN
    localparam int EMPTY_CYC = 8;
    localparam int DUMMY_REQ = 2;
`else
    localparam int EMPTY_CYC = 6;
    localparam int DUMMY_REQ = 0;
`endif
    localparam int LD_EDGE = EMPTY_CYC - 1;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        ce = 1'b1;
    logic        i_fetch_start = 1'b0;
    logic        i_obj_size = 1'b0;
    logic        i_pat_base = 1'b0;
    logic [4:0]  o_temp_addr;
    logic [7:0]  i_temp_data;
    logic        o_pat_req;
    logic [12:0] o_pat_addr;
    logic        i_pat_ack = 1'b1;
    logic [7:0]  i_pat_data;
    logic [3:0]  o_load;
    logic [26:0] o_load_data;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  temp_mem [0:31];
    logic [7:0]  pat_mem  [0:8191];
    logic [7:0]  temp_rd = 8'h00;
    logic [26:0] load_q [$];
    logic [12:0] addr_q [$];

    sprite_fetch #(.PAT_AW(13)) dut (
        .clk          (clk),
        .i_rst_n      (i_rst_n),
        .ce           (ce),
        .i_fetch_start(i_fetch_start),
        .i_obj_size   (i_obj_size),
        .i_pat_base   (i_pat_base),
        .o_temp_addr  (o_temp_addr),
        .i_temp_data  (i_temp_data),
        .o_pat_req    (o_pat_req),
        .o_pat_addr   (o_pat_addr),
        .i_pat_ack    (i_pat_ack),
        .i_pat_data   (i_pat_data),
        .o_load       (o_load),
        .o_load_data  (o_load_data),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) if (ce) temp_rd <= temp_mem[o_temp_addr];
    assign i_temp_data = temp_rd;
    assign i_pat_data  = pat_mem[o_pat_addr];

    always @(negedge clk) begin
        if (o_load != 4'h0) load_q.push_back(o_load_data);
        if (o_pat_req && i_pat_ack && ce) addr_q.push_back(o_pat_addr);
    end

    task automatic fill_empty();
        for (int i = 0; i < 32; i++) temp_mem[i] = 8'hFF;
    endtask

    task automatic set_slot(input int s, input logic [7:0] y, input logic [7:0] t,
                            input logic [7:0] a, input logic [7:0] x);
        temp_mem[s*4+0] = y;
        temp_mem[s*4+1] = t;
        temp_mem[s*4+2] = a;
        temp_mem[s*4+3] = x;
    endtask

    task automatic run_fetch(output int cycles, output bit timed_out);
        int s;
        load_q.delete();
        addr_q.delete();
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(posedge clk);
        #1 i_fetch_start = 1'b0;
        s = cyc;
        cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (o_done) begin
                cycles = cyc - s;
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (o_temp_addr !== 5'd0) begin errors++; $display("[TB] FAIL reset_temp_addr: got %h expected 0", o_temp_addr); end
        checks++; if (o_pat_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_pat_req: got %b expected 0", o_pat_req); end
        checks++; if (o_pat_addr !== 13'd0) begin errors++; $display("[TB] FAIL reset_pat_addr: got %h expected 0", o_pat_addr); end
        checks++; if (o_load !== 4'h0) begin errors++; $display("[TB] FAIL reset_load: got %h expected 0", o_load); end
        checks++; if (o_load_data !== 27'd0) begin errors++; $display("[TB] FAIL reset_load_data: got %h expected 0", o_load_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", o_done); end
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", o_busy); end
    endtask

    task automatic test_basic_8x8();
        int cycles;
        bit to;
        fill_empty();
        set_slot(0, 8'h03, 8'h12, 8'h00, 8'h40);
        pat_mem[13'h0123] = 8'h80;
        pat_mem[13'h012B] = 8'h01;
        i_obj_size = 1'b0;
        i_pat_base = 1'b0;
        run_fetch(cycles, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL basic_timeout: got no o_done expected o_done"); end
        checks++; if (cycles != 8 + 7*EMPTY_CYC) begin errors++; $display("[TB] FAIL basic_cycles: got %0d expected %0d", cycles, 8 + 7*EMPTY_CYC); end
        checks++; if (addr_q.size() != 2 + 7*DUMMY_REQ) begin errors++; $display("[TB] FAIL basic_req_count: got %0d expected %0d", addr_q.size(), 2 + 7*DUMMY_REQ); end
        checks++; if (addr_q[0] !== 13'h0123) begin errors++; $display("[TB] FAIL basic_lo_addr: got %h expected 0123", addr_q[0]); end
        checks++; if (addr_q[1] !== 13'h012B) begin errors++; $display("[TB] FAIL basic_hi_addr: got %h expected 012B", addr_q[1]); end
        checks++; if (load_q.size() != 8) begin errors++; $display("[TB] FAIL basic_load_count: got %0d expected 8", load_q.size()); end
        checks++; if (load_q[0] !== {8'h01, 8'h80, 8'h40, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL basic_load0: got %h expected %h", load_q[0], {8'h01, 8'h80, 8'h40, 2'b00, 1'b0}); end
        checks++; if (load_q[1] !== {8'h00, 8'h00, 8'hFF, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL basic_load1_empty: got %h expected %h", load_q[1], {8'h00, 8'h00, 8'hFF, 2'b00, 1'b0}); end
    endtask

    task automatic test_flip();
        int cycles;
        bit to;
        fill_empty();
        set_slot(0, 8'h03, 8'h12, 8'hC3, 8'h40);
        pat_mem[13'h0124] = 8'h80;
        pat_mem[13'h012C] = 8'h01;
        run_fetch(cycles, to);
        checks++; if (addr_q[0] !== 13'h0124) begin errors++; $display("[TB] FAIL flip_lo_addr: got %h expected 0124", addr_q[0]); end
        checks++; if (addr_q[1] !== 13'h012C) begin errors++; $display("[TB] FAIL flip_hi_addr: got %h expected 012C", addr_q[1]); end
        checks++; if (load_q[0] !== {8'h80, 8'h01, 8'h40, 2'b11, 1'b0}) begin errors++; $display("[TB] FAIL flip_load0: got %h expected %h", load_q[0], {8'h80, 8'h01, 8'h40, 2'b11, 1'b0}); end
    endtask

    task automatic test_8x16();
        int cycles;
        bit to;
        fill_empty();
        set_slot(0, 8'h0A, 8'h25, 8'h21, 8'h10);
        pat_mem[13'h1252] = 8'h0F;
        pat_mem[13'h125A] = 8'hF0;
        i_obj_size = 1'b1;
        run_fetch(cycles, to);
        i_obj_size = 1'b0;
        checks++; if (addr_q[0] !== 13'h1252) begin errors++; $display("[TB] FAIL tall_lo_addr: got %h expected 1252", addr_q[0]); end
        checks++; if (addr_q[1] !== 13'h125A) begin errors++; $display("[TB] FAIL tall_hi_addr: got %h expected 125A", addr_q[1]); end
        checks++; if (load_q[0] !== {8'hF0, 8'h0F, 8'h10, 2'b01, 1'b1}) begin errors++; $display("[TB] FAIL tall_load0: got %h expected %h", load_q[0], {8'hF0, 8'h0F, 8'h10, 2'b01, 1'b1}); end
    endtask

    task automatic test_all_empty();
        int cycles;
        bit to;
        int bad;
        fill_empty();
        run_fetch(cycles, to);
        checks++; if (cycles != 8*EMPTY_CYC) begin errors++; $display("[TB] FAIL empty_cycles: got %0d expected %0d", cycles, 8*EMPTY_CYC); end
        checks++; if (addr_q.size() != 8*DUMMY_REQ) begin errors++; $display("[TB] FAIL empty_req_count: got %0d expected %0d", addr_q.size(), 8*DUMMY_REQ); end
        checks++; if (load_q.size() != 8) begin errors++; $display("[TB] FAIL empty_load_count: got %0d expected 8", load_q.size()); end
        bad = 0;
        foreach (load_q[i]) if (load_q[i] !== {8'h00, 8'h00, 8'hFF, 2'b00, 1'b0}) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL empty_load_values: got %0d wrong records expected 0", bad); end
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] !== ((i % 2 == 0) ? 13'h0FF0 : 13'h0FF8)) bad++;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL empty_dummy_addr: got %0d wrong addresses expected 0", bad); end
    endtask

    task automatic test_ack_stall();
        int s;
        bit found;
        bit done_seen;
        int cycles;
        fill_empty();
        set_slot(2, 8'h05, 8'h33, 8'h40, 8'h77);
        pat_mem[13'h1335] = 8'h3C;
        pat_mem[13'h133D] = 8'hA5;
        i_pat_base = 1'b1;
        load_q.delete();
        addr_q.delete();
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(posedge clk);
        #1 i_fetch_start = 1'b0;
        s = cyc;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_temp_addr == 5'h0B) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL stall_reach_slot2: got not found expected found"); end
        @(posedge clk);
        @(posedge clk);
        #1 i_pat_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (o_pat_req !== 1'b1) begin errors++; $display("[TB] FAIL stall_req[%0d]: got %b expected 1", i, o_pat_req); end
            checks++; if (o_pat_addr !== 13'h1335) begin errors++; $display("[TB] FAIL stall_addr[%0d]: got %h expected 1335", i, o_pat_addr); end
            checks++; if (o_load !== 4'h0) begin errors++; $display("[TB] FAIL stall_load[%0d]: got %h expected 0", i, o_load); end
            @(posedge clk);
        end
        #1 i_pat_ack = 1'b1;
        done_seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_done) begin done_seen = 1'b1; cycles = cyc - s; break; end
        end
        i_pat_base = 1'b0;
        checks++; if (!done_seen) begin errors++; $display("[TB] FAIL stall_timeout: got no o_done expected o_done"); end
        checks++; if (cycles != 8 + 7*EMPTY_CYC + 5) begin errors++; $display("[TB] FAIL stall_cycles: got %0d expected %0d", cycles, 8 + 7*EMPTY_CYC + 5); end
        checks++; if (load_q[2] !== {8'h3C, 8'hA5, 8'h77, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL stall_load2: got %h expected %h", load_q[2], {8'h3C, 8'hA5, 8'h77, 2'b00, 1'b0}); end
    endtask

    task automatic test_ce_gating();
        int s;
        bit done_seen;
        int cycles;
        fill_empty();
        load_q.delete();
        addr_q.delete();
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(posedge clk);
        #1 i_fetch_start = 1'b0;
        s = cyc;
        repeat (LD_EDGE) @(posedge clk);
        #1 ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_load !== 4'h0) begin errors++; $display("[TB] FAIL ce_load_gated[%0d]: got %h expected 0", i, o_load); end
            checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL ce_busy[%0d]: got %b expected 1", i, o_busy); end
            @(posedge clk);
        end
        #1 ce = 1'b1;
        @(negedge clk);
        checks++; if (o_load !== 4'hF) begin errors++; $display("[TB] FAIL ce_load_resume: got %h expected F", o_load); end
        done_seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_done) begin done_seen = 1'b1; cycles = cyc - s; break; end
            @(negedge clk);
        end
        checks++; if (!done_seen || cycles != 8*EMPTY_CYC + 3) begin errors++; $display("[TB] FAIL ce_cycles: got %0d expected %0d", cycles, 8*EMPTY_CYC + 3); end
        checks++; if (load_q.size() != 8) begin errors++; $display("[TB] FAIL ce_load_count: got %0d expected 8", load_q.size()); end
    endtask

    task automatic test_back_to_back();
        int s;
        bit done_seen;
        int cycles;
        bit to;
        fill_empty();
        load_q.delete();
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(posedge clk);
        #1 i_fetch_start = 1'b0;
        s = cyc;
        repeat (10) @(negedge clk);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("[TB] FAIL b2b_busy: got %b expected 1", o_busy); end
        i_fetch_start = 1'b1;
        @(negedge clk);
        i_fetch_start = 1'b0;
        done_seen = 1'b0;
        cycles = 0;
        for (int i = 0; i < 200; i++) begin
            if (o_done) begin done_seen = 1'b1; cycles = cyc - s; break; end
            @(negedge clk);
        end
        checks++; if (!done_seen || cycles != 8*EMPTY_CYC) begin errors++; $display("[TB] FAIL b2b_ignored_start: got %0d expected %0d", cycles, 8*EMPTY_CYC); end
        checks++; if (load_q.size() != 8) begin errors++; $display("[TB] FAIL b2b_load_count: got %0d expected 8", load_q.size()); end
        run_fetch(cycles, to);
        checks++; if (to || cycles != 8*EMPTY_CYC) begin errors++; $display("[TB] FAIL b2b_second: got %0d expected %0d", cycles, 8*EMPTY_CYC); end
    endtask

    task automatic test_abort_reset();
        bit found;
        int cycles;
        bit to;
        fill_empty();
        set_slot(4, 8'h01, 8'h44, 8'h00, 8'h55);
        pat_mem[13'h0441] = 8'h03;
        pat_mem[13'h0449] = 8'h00;
        load_q.delete();
        @(negedge clk);
        i_fetch_start = 1'b1;
        @(posedge clk);
        #1 i_fetch_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (o_pat_req && o_pat_addr == 13'h0449) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("[TB] FAIL abort_reach_p1: got not found expected found"); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_pat_req !== 1'b0) begin errors++; $display("[TB] FAIL abort_pat_req: got %b expected 0", o_pat_req); end
        checks++; if (o_pat_addr !== 13'd0) begin errors++; $display("[TB] FAIL abort_pat_addr: got %h expected 0", o_pat_addr); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy: got %b expected 0", o_busy); end
        checks++; if (o_load !== 4'h0 || o_load_data !== 27'd0) begin errors++; $display("[TB] FAIL abort_load: got %h/%h expected 0/0", o_load, o_load_data); end
        checks++; if (o_done !== 1'b0 || o_temp_addr !== 5'd0) begin errors++; $display("[TB] FAIL abort_done_addr: got %b/%h expected 0/0", o_done, o_temp_addr); end
        checks++; if (load_q.size() != 4) begin errors++; $display("[TB] FAIL abort_partial: got %0d loads expected 4", load_q.size()); end
        repeat (2) @(negedge clk);
        i_rst_n = 1'b1;
        run_fetch(cycles, to);
        checks++; if (to || cycles != 8 + 7*EMPTY_CYC) begin errors++; $display("[TB] FAIL abort_refetch_cycles: got %0d expected %0d", cycles, 8 + 7*EMPTY_CYC); end
        checks++; if (load_q.size() != 8) begin errors++; $display("[TB] FAIL abort_refetch_count: got %0d expected 8", load_q.size()); end
        checks++; if (load_q[4] !== {8'hC0, 8'h00, 8'h55, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL abort_refetch_load4: got %h expected %h", load_q[4], {8'hC0, 8'h00, 8'h55, 2'b00, 1'b0}); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) pat_mem[i] = 8'h00;
        fill_empty();
        $display("[TB] sprite_fetch bench start");
        test_reset();
        test_basic_8x8();
        test_flip();
        test_8x16();
        test_all_empty();
        test_ack_stall();
        test_ce_gating();
        test_back_to_back();
        test_abort_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
